// File: rtl/sha256_pkg.sv
// Shared constants for the SHA-256 message padder: FSM encodings, pad byte
// and the fixed SHA-256 widths.
package sha256_pkg;
  localparam int BLOCK_W = 512;
  localparam int WORD_W  = 32;
  localparam int LEN_W   = 64;

  localparam logic [7:0] PAD_BYTE = 8'h80;

  localparam logic [2:0] ST_COLLECT   = 3'd0;
  localparam logic [2:0] ST_ISSUE     = 3'd1;
  localparam logic [2:0] ST_WAIT_LOW  = 3'd2;
  localparam logic [2:0] ST_WAIT_HIGH = 3'd3;
  localparam logic [2:0] ST_EXTRA     = 3'd4;
endpackage

// File: rtl/sha256_pad_word.sv
// Masks the unused low bytes of a final partial word and places the 0x80
// pad byte right after the last valid byte.
module sha256_pad_word
  import sha256_pkg::*;
(
  input  logic [WORD_W-1:0] word_i,
  input  logic [1:0]        bytes_i,
  input  logic              pad_i,
  output logic [WORD_W-1:0] word_o
);

  always_comb begin
    word_o = word_i;
    if (pad_i) begin
      case (bytes_i)
        2'd1:    word_o = {word_i[31:24], PAD_BYTE, 16'h0000};
        2'd2:    word_o = {word_i[31:16], PAD_BYTE, 8'h00};
        2'd3:    word_o = {word_i[31:8], PAD_BYTE};
        default: word_o = word_i;
      endcase
    end
  end

endmodule

// File: rtl/sha256_msg_padder.sv
// Assembles 32-bit message words into padded 512-bit SHA-256 blocks and
// hands each block to the core with an init/next pulse paced by core_ready.
module sha256_msg_padder
  import sha256_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [WORD_W-1:0]  s_data,
  input  logic               s_last,
  input  logic [1:0]         s_bytes,
  input  logic               mode_i,
  input  logic               core_ready,
  output logic               core_init,
  output logic               core_next,
  output logic               core_mode,
  output logic [BLOCK_W-1:0] core_block,
  output logic               busy
);

  logic [2:0]         state_q, state_d;
  logic [3:0]         widx_q, widx_d;
  logic [LEN_W-1:0]   bitlen_q, bitlen_d;
  // cont_q is the inverse of "first block": zero after reset means init next
  logic               cont_q, cont_d;
  logic               need_extra_q, need_extra_d;
  logic               pad_pending_q, pad_pending_d;
  logic               msg_end_q, msg_end_d;
  logic               busy_q, busy_d;
  logic               mode_q, mode_d;
  logic               init_q, init_d;
  logic               next_q, next_d;
  logic [BLOCK_W-1:0] block_q, block_d;

  logic [WORD_W-1:0]  padded_word;
  logic [5:0]         add_bits;
  logic [LEN_W-1:0]   bitlen_new;
  logic               len_here;

  sha256_pad_word u_pad_word (
    .word_i  (s_data),
    .bytes_i (s_bytes),
    .pad_i   (s_last),
    .word_o  (padded_word)
  );

  assign add_bits   = (s_last && s_bytes != 2'd0) ? {1'b0, s_bytes, 3'b000} : 6'd32;
  assign bitlen_new = (busy_q ? bitlen_q : '0) + {58'd0, add_bits};
  // Length fits when the pad byte lands no later than word 13
  assign len_here   = (s_bytes != 2'd0) ? (widx_q <= 4'd13) : (widx_q <= 4'd12);

  always_comb begin
    state_d       = state_q;
    widx_d        = widx_q;
    bitlen_d      = bitlen_q;
    cont_d        = cont_q;
    need_extra_d  = need_extra_q;
    pad_pending_d = pad_pending_q;
    msg_end_d     = msg_end_q;
    busy_d        = busy_q;
    mode_d        = mode_q;
    block_d       = block_q;
    init_d        = 1'b0;
    next_d        = 1'b0;

    case (state_q)
      ST_COLLECT: begin
        if (s_valid) begin
          busy_d   = 1'b1;
          bitlen_d = bitlen_new;
          if (!busy_q) mode_d = mode_i;
          if (!s_last) begin
            block_d[BLOCK_W-1-WORD_W*int'(widx_q) -: WORD_W] = s_data;
            if (widx_q == 4'd15) state_d = ST_ISSUE;
            else                 widx_d  = widx_q + 4'd1;
          end else begin
            for (int i = 0; i < 16; i++) begin
              if (i == int'(widx_q)) begin
                block_d[BLOCK_W-1-WORD_W*i -: WORD_W] = padded_word;
              end else if (i > int'(widx_q)) begin
                if (s_bytes == 2'd0 && i == int'(widx_q) + 1)
                  block_d[BLOCK_W-1-WORD_W*i -: WORD_W] = {PAD_BYTE, 24'h000000};
                else
                  block_d[BLOCK_W-1-WORD_W*i -: WORD_W] = '0;
              end
            end
            if (len_here) block_d[LEN_W-1:0] = bitlen_new;
            need_extra_d  = ~len_here;
            pad_pending_d = (s_bytes == 2'd0) && (widx_q == 4'd15);
            msg_end_d     = 1'b1;
            state_d       = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (core_ready) begin
          init_d  = ~cont_q;
          next_d  = cont_q;
          cont_d  = 1'b1;
          state_d = ST_WAIT_LOW;
        end
      end
      ST_WAIT_LOW: begin
        if (!core_ready) state_d = ST_WAIT_HIGH;
      end
      ST_WAIT_HIGH: begin
        if (core_ready) begin
          if (need_extra_q) begin
            state_d = ST_EXTRA;
          end else begin
            state_d = ST_COLLECT;
            widx_d  = 4'd0;
            if (msg_end_q) begin
              busy_d    = 1'b0;
              cont_d    = 1'b0;
              msg_end_d = 1'b0;
            end
          end
        end
      end
      ST_EXTRA: begin
        block_d = '0;
        if (pad_pending_q) block_d[BLOCK_W-1 -: WORD_W] = {PAD_BYTE, 24'h000000};
        block_d[LEN_W-1:0] = bitlen_q;
        need_extra_d  = 1'b0;
        pad_pending_d = 1'b0;
        state_d       = ST_ISSUE;
      end
      default: state_d = ST_COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= ST_COLLECT;
      widx_q        <= '0;
      bitlen_q      <= '0;
      cont_q        <= 1'b0;
      need_extra_q  <= 1'b0;
      pad_pending_q <= 1'b0;
      msg_end_q     <= 1'b0;
      busy_q        <= 1'b0;
      mode_q        <= 1'b0;
      init_q        <= 1'b0;
      next_q        <= 1'b0;
      block_q       <= '0;
    end else begin
      state_q       <= state_d;
      widx_q        <= widx_d;
      bitlen_q      <= bitlen_d;
      cont_q        <= cont_d;
      need_extra_q  <= need_extra_d;
      pad_pending_q <= pad_pending_d;
      msg_end_q     <= msg_end_d;
      busy_q        <= busy_d;
      mode_q        <= mode_d;
      init_q        <= init_d;
      next_q        <= next_d;
      block_q       <= block_d;
    end
  end

  assign s_ready    = (state_q == ST_COLLECT);
  assign core_init  = init_q;
  assign core_next  = next_q;
  assign core_mode  = mode_q;
  assign core_block = block_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Bench for sha256_msg_padder: byte-level padding reference feeding a block
// scoreboard, plus a simple core model that drops ready after each pulse.
module tb_sha256_msg_padder;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [31:0]  s_data = '0;
  logic         s_last = 1'b0;
  logic [1:0]   s_bytes = '0;
  logic         mode_i = 1'b0;
  logic         core_ready;
  logic         core_init;
  logic         core_next;
  logic         core_mode;
  logic [511:0] core_block;
  logic         busy;

  typedef struct {
    bit           init;
    bit           mode;
    logic [511:0] blk;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] msg[$];
  int         n_pass = 0;
  int         n_chk = 0;
  int         pulse_cnt = 0;
  int         core_busy = 0;
  bit         hold_ready = 1'b0;

  sha256_msg_padder dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_last     (s_last),
    .s_bytes    (s_bytes),
    .mode_i     (mode_i),
    .core_ready (core_ready),
    .core_init  (core_init),
    .core_next  (core_next),
    .core_mode  (core_mode),
    .core_block (core_block),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Core model: busy for a few cycles after each pulse
  assign core_ready = (core_busy == 0) && !hold_ready;
  always @(posedge clk) begin
    if (core_init || core_next) core_busy <= 4;
    else if (core_busy > 0)     core_busy <= core_busy - 1;
  end

  task automatic check1(string tag, logic got, logic exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0b expected %0b", tag, got, exp);
  endtask

  task automatic checkw(string tag, logic [511:0] got, logic [511:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (core_init === 1'b1 || core_next === 1'b1) begin
      pulse_cnt++;
      if (sb.size() == 0) begin
        check1("unexpected_pulse", 1'b1, 1'b0);
      end else begin
        e = sb.pop_front();
        check1("pulse_init", core_init, e.init);
        check1("pulse_next", core_next, !e.init);
        check1("pulse_mode", core_mode, e.mode);
        checkw("pulse_block", core_block, e.blk);
      end
    end
  end

  function automatic void push_expected(bit mode);
    logic [7:0]   p[$];
    logic [63:0]  bits;
    logic [511:0] blk;
    bit           first;
    first = 1'b1;
    p = msg;
    bits = 64'(msg.size()) * 64'd8;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int k = 7; k >= 0; k--) p.push_back(bits[8*k +: 8]);
    for (int b = 0; b < p.size() / 64; b++) begin
      for (int j = 0; j < 64; j++) blk[511-8*j -: 8] = p[64*b+j];
      sb.push_back('{init: first, mode: mode, blk: blk});
      first = 1'b0;
    end
  endfunction

  function automatic void build_msg(int len, logic [7:0] seed);
    msg.delete();
    for (int i = 0; i < len; i++) msg.push_back(seed + 8'(i * 7));
  endfunction

  // Called at a negedge; returns at a negedge after the last word is taken
  task automatic send_msg(bit mode);
    int         len;
    int         nw;
    int         t;
    logic [31:0] d;
    len = msg.size();
    nw  = (len + 3) / 4;
    for (int w = 0; w < nw; w++) begin
      d = 32'hA5A5A5A5;
      for (int b = 0; b < 4; b++)
        if (4*w + b < len) d[31-8*b -: 8] = msg[4*w+b];
      s_valid = 1'b1;
      s_data  = d;
      s_last  = (w == nw - 1);
      s_bytes = 2'(len % 4);
      mode_i  = (w == 0) ? mode : !mode;
      t = 0;
      while (!s_ready && t < 3000) begin
        @(negedge clk);
        t++;
      end
      if (!s_ready) check1("accept_timeout", 1'b0, 1'b1);
      @(negedge clk);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_idle(string tag);
    int t;
    t = 0;
    while ((busy || sb.size() != 0) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check1({tag, "_done"}, (busy == 1'b0) && (sb.size() == 0), 1'b1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int base;
    int t;

    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check1("rst_s_ready", s_ready, 1'b1);
    check1("rst_busy", busy, 1'b0);
    check1("rst_init", core_init, 1'b0);
    check1("rst_next", core_next, 1'b0);
    check1("rst_mode", core_mode, 1'b0);
    checkw("rst_block", core_block, '0);
    reset_n = 1'b1;
    @(negedge clk);

    msg = {8'h61, 8'h62, 8'h63};
    push_expected(1'b1);
    send_msg(1'b1);
    wait_idle("abc");

    build_msg(56, 8'h10);
    push_expected(1'b0);
    send_msg(1'b0);
    wait_idle("m56");

    build_msg(64, 8'h20);
    push_expected(1'b1);
    send_msg(1'b1);
    wait_idle("m64");

    build_msg(55, 8'h30);
    push_expected(1'b0);
    send_msg(1'b0);
    wait_idle("m55");

    build_msg(61, 8'h44);
    push_expected(1'b1);
    send_msg(1'b1);
    wait_idle("m61");

    build_msg(52, 8'h51);
    push_expected(1'b0);
    send_msg(1'b0);
    wait_idle("m52");

    build_msg(130, 8'h05);
    push_expected(1'b1);
    send_msg(1'b1);
    wait_idle("m130");

    // Backpressure: core not ready while the block waits in ISSUE
    hold_ready = 1'b1;
    msg = {8'h61, 8'h62, 8'h63};
    push_expected(1'b0);
    send_msg(1'b0);
    base = pulse_cnt;
    repeat (5) @(negedge clk);
    check1("bp_s_ready", s_ready, 1'b0);
    check1("bp_busy", busy, 1'b1);
    check1("bp_no_pulse", pulse_cnt == base, 1'b1);
    hold_ready = 1'b0;
    @(negedge clk);
    check1("bp_init", core_init, 1'b1);
    @(negedge clk);
    check1("bp_single", core_init, 1'b0);
    wait_idle("bp");

    // Reset while waiting for the core to drop ready after block 1
    build_msg(56, 8'h70);
    push_expected(1'b1);
    void'(sb.pop_back());
    send_msg(1'b1);
    t = 0;
    while (!core_init && t < 500) begin
      @(negedge clk);
      t++;
    end
    check1("rst_mid_first_pulse", core_init, 1'b1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check1("rst_mid_s_ready", s_ready, 1'b1);
    check1("rst_mid_busy", busy, 1'b0);
    checkw("rst_mid_block", core_block, '0);
    base = pulse_cnt;
    repeat (30) @(negedge clk);
    check1("rst_mid_no_next", pulse_cnt == base, 1'b1);
    check1("rst_mid_sb_empty", sb.size() == 0, 1'b1);

    msg = {8'h61, 8'h62, 8'h63};
    push_expected(1'b1);
    send_msg(1'b1);
    wait_idle("abc_after_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
